// File: rtl/lif_pkg.sv
// Shared types, default widths and the saturating-add helper for the LIF monitor blocks.
package lif_pkg;

  localparam int unsigned CNT_W_DEF      = 8;
  localparam int unsigned TIMER_W_DEF    = 16;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } lif_state_e;

  // Add a and b, clamping at the largest value representable in w bits (w <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    sum   = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_v}) begin
      return max_v;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/lif_sync_fifo.sv
// Small synchronous FIFO with registered write and a combinational head output.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module lif_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/lif_spike_rate_monitor.sv
// Spike-rate monitor: counts LIF spikes per programmable window, queues window
// counts in a FIFO for readout, and tracks the minimum inter-spike interval.
//
// state | meaning
// IDLE  | disabled; timer/count held at zero, waiting for en
// RUN   | counting spikes; window end pushes the count and restarts
// FLUSH | en dropped mid-window; push the partial count, return to IDLE
//
// If en drops on the last cycle of a window the full window is pushed and the
// FSM returns straight to IDLE, so no empty partial window follows it and a
// one-cycle window length cannot keep the FSM in RUN after en is removed.
module lif_spike_rate_monitor
  import lif_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned TIMER_W    = TIMER_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          spike_in,
  input  logic [TIMER_W-1:0]            win_len,
  input  logic                          rd_ready,
  output logic                          rd_valid,
  output logic [CNT_W-1:0]              rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [TIMER_W-1:0]            isi_min,
  output logic                          ovf
);

  lif_state_e         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TIMER_W-1:0] win_len_q, win_len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TIMER_W-1:0] isi_cnt_q, isi_cnt_d;
  logic [TIMER_W-1:0] isi_min_q, isi_min_d;
  logic               isi_armed_q, isi_armed_d;
  logic               ovf_q, ovf_d;

  logic [TIMER_W-1:0] win_len_eff;
  logic [CNT_W-1:0]   cnt_plus;
  logic [TIMER_W-1:0] isi_inc;
  logic               last_cycle;
  logic               spike_acc;
  logic               push;
  logic [CNT_W-1:0]   push_data;
  logic               fifo_full, fifo_empty, pop;

  assign win_len_eff = (win_len == '0) ? TIMER_W'(1) : win_len;
  assign cnt_plus    = CNT_W'(sat_add(32'(cnt_q), 32'(spike_in), CNT_W));
  assign isi_inc     = TIMER_W'(sat_add(32'(isi_cnt_q), 32'd1, TIMER_W));
  assign last_cycle  = (timer_q == win_len_q - TIMER_W'(1));
  assign pop         = rd_ready && !fifo_empty;

  // Window FSM: next state, timer, counter and FIFO push.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    cnt_d     = cnt_q;
    win_len_d = win_len_q;
    push      = 1'b0;
    push_data = cnt_q;
    spike_acc = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        cnt_d   = '0;
        if (en) begin
          win_len_d = win_len_eff;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (last_cycle) begin
          push      = 1'b1;
          push_data = cnt_plus;
          spike_acc = spike_in;
          cnt_d     = '0;
          timer_d   = '0;
          win_len_d = win_len_eff;
          state_d   = en ? RUN : IDLE;
        end else if (!en) begin
          state_d = FLUSH;
        end else begin
          spike_acc = spike_in;
          cnt_d     = cnt_plus;
          timer_d   = timer_q + TIMER_W'(1);
        end
      end
      FLUSH: begin
        push      = 1'b1;
        push_data = cnt_q;
        cnt_d     = '0;
        timer_d   = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ISI tracking and sticky overflow; the first counted spike only arms the tracker.
  always_comb begin
    isi_cnt_d   = isi_cnt_q;
    isi_min_d   = isi_min_q;
    isi_armed_d = isi_armed_q;
    ovf_d       = ovf_q;
    if (state_q == RUN) begin
      if (spike_acc) begin
        if (isi_armed_q && (isi_inc < isi_min_q)) isi_min_d = isi_inc;
        isi_armed_d = 1'b1;
        isi_cnt_d   = '0;
      end else begin
        isi_cnt_d = isi_inc;
      end
    end
    if (push && fifo_full && !pop) ovf_d = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      win_len_q   <= TIMER_W'(1);
      cnt_q       <= '0;
      isi_cnt_q   <= '0;
      isi_min_q   <= '1;
      isi_armed_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      win_len_q   <= win_len_d;
      cnt_q       <= cnt_d;
      isi_cnt_q   <= isi_cnt_d;
      isi_min_q   <= isi_min_d;
      isi_armed_q <= isi_armed_d;
      ovf_q       <= ovf_d;
    end
  end

  lif_sync_fifo #(
    .WIDTH (CNT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (push_data),
    .pop_i   (rd_ready),
    .rdata_o (rd_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign rd_valid = !fifo_empty;
  assign isi_min  = isi_min_q;
  assign ovf      = ovf_q;

endmodule
